// File: rtl/layer_bias_rx_pkg.sv
// Shared sizing, FSM encoding and saturation limits for the layer-0 bias receiver.
package layer_bias_pkg;

    localparam int CH_NUM   = 16;
    localparam int BEAT_NUM = CH_NUM / 2;
    localparam int DW       = 32;
    localparam int CH_W     = $clog2(CH_NUM);
    localparam int BEAT_W   = $clog2(BEAT_NUM);

    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_NUM - 1);

    localparam logic [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/layer_bias_rx_if.sv
// Bias load stream: arm pulse plus a 64-bit valid/ready/last beat channel.
interface layer_bias_rx_if;
    import layer_bias_pkg::*;

    logic            load_start;
    logic [2*DW-1:0] bias_data;
    logic            bias_valid;
    logic            bias_last;
    logic            ready;

    modport master (
        output load_start,
        output bias_data,
        output bias_valid,
        output bias_last,
        input  ready
    );

    modport slave (
        input  load_start,
        input  bias_data,
        input  bias_valid,
        input  bias_last,
        output ready
    );

endinterface

// File: rtl/layer_bias_rx_sat_add.sv
// Combinational signed add of two DW-bit words, clamped to the DW-bit signed range.
module bias_sat_add
    import layer_bias_pkg::*;
(
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    output logic [DW-1:0] o_y
);

    logic [DW:0] w_sum;

    assign w_sum = {i_a[DW-1], i_a} + {i_b[DW-1], i_b};

    // The two top bits of the extended sum disagree exactly when DW bits overflow.
    always_comb begin
        o_y = w_sum[DW-1:0];
        if (w_sum[DW] != w_sum[DW-1])
            o_y = w_sum[DW] ? SAT_MIN : SAT_MAX;
    end

endmodule

// File: rtl/layer_bias_rx.sv
// Receives the layer-0 bias stream into a per-channel register file and adds the
// selected bias to accumulator results through one saturating, registered stage.
module layer_bias_rx
    import layer_bias_pkg::*;
(
    input  logic                 sclk,
    input  logic                 s_rst_n,
    layer_bias_rx_if.slave       bias_if,
    input  logic [DW-1:0]        i_acc_data,
    input  logic                 i_acc_valid,
    input  logic [CH_W-1:0]      i_acc_ch,
    output logic [DW-1:0]        o_out_data,
    output logic                 o_out_valid,
    output logic                 o_bias_loaded,
    output logic                 o_load_err
);

    state_e                      r_state;
    state_e                      w_state_nxt;
    logic [BEAT_W-1:0]           r_cnt;
    logic [CH_NUM-1:0][DW-1:0]   r_bias;
    logic                        r_load_err;
    logic [DW-1:0]               r_out_data;
    logic                        r_out_valid;

    logic                        w_ready;
    logic                        w_accept;
    logic                        w_last_beat;
    logic                        w_frame_err;
    logic                        w_loaded;
    logic [DW-1:0]               w_bias_sel;
    logic [DW-1:0]               w_sum_sat;

    // A beat arriving together with load_start belongs to the aborted load.
    assign w_accept    = bias_if.bias_valid && w_ready && !bias_if.load_start;
    assign w_last_beat = (r_cnt == BEAT_LAST);
    assign w_frame_err = w_accept && (bias_if.bias_last != w_last_beat);

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_loaded    = 1'b0;
        case (r_state)
            IDLE: ;
            LOAD: begin
                w_ready = 1'b1;
                if (w_accept) begin
                    if (bias_if.bias_last && w_last_beat)
                        w_state_nxt = DONE;
                    else if (bias_if.bias_last || w_last_beat)
                        w_state_nxt = IDLE;
                end
            end
            DONE: w_loaded = 1'b1;
            default: w_state_nxt = IDLE;
        endcase
        if (bias_if.load_start)
            w_state_nxt = LOAD;
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_cnt      <= '0;
            r_load_err <= 1'b0;
        end else if (bias_if.load_start) begin
            r_cnt      <= '0;
            r_load_err <= 1'b0;
        end else begin
            if (w_accept)
                r_cnt <= r_cnt + 1'b1;
            if (w_frame_err)
                r_load_err <= 1'b1;
        end
    end

    // Malformed beats are still written; only bias_loaded protects consumers.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_bias <= '0;
        end else if (w_accept) begin
            r_bias[{r_cnt, 1'b0}] <= bias_if.bias_data[DW-1:0];
            r_bias[{r_cnt, 1'b1}] <= bias_if.bias_data[2*DW-1:DW];
        end
    end

    assign w_bias_sel = r_bias[i_acc_ch];

    bias_sat_add u_sat_add (
        .i_a (i_acc_data),
        .i_b (w_bias_sel),
        .o_y (w_sum_sat)
    );

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= i_acc_valid && w_loaded;
            if (i_acc_valid && w_loaded)
                r_out_data <= w_sum_sat;
        end
    end

    assign bias_if.ready = w_ready;
    assign o_out_data    = r_out_data;
    assign o_out_valid   = r_out_valid;
    assign o_bias_loaded = w_loaded;
    assign o_load_err    = r_load_err;

endmodule

// File: tb/tb_layer_bias_rx.sv
// Directed and randomized checks of layer_bias_rx against a per-beat behavioural model.
module tb_layer_bias_rx;
    import layer_bias_pkg::*;

    logic sclk = 1'b0;
    logic s_rst_n;
    always #5 sclk = ~sclk;

    layer_bias_rx_if bif();

    logic [DW-1:0]   acc_data;
    logic            acc_valid;
    logic [CH_W-1:0] acc_ch;
    logic [DW-1:0]   out_data;
    logic            out_valid;
    logic            bias_loaded;
    logic            load_err;

    layer_bias_rx dut (
        .sclk          (sclk),
        .s_rst_n       (s_rst_n),
        .bias_if       (bif),
        .i_acc_data    (acc_data),
        .i_acc_valid   (acc_valid),
        .i_acc_ch      (acc_ch),
        .o_out_data    (out_data),
        .o_out_valid   (out_valid),
        .o_bias_loaded (bias_loaded),
        .o_load_err    (load_err)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: bias words, whether a load is in progress, next beat index, status flags.
    int          m_bias [CH_NUM];
    bit          m_loading, m_loaded, m_err;
    int          m_idx;
    logic [31:0] m_out;

    int B1 [CH_NUM] = '{129, 395, -1099, 473, 119, 698, 537, 818,
                        -108, 1009, 364, 225, -2467, -162, 368, -174};
    int B5 [CH_NUM] = '{default: 5};
    int BR [CH_NUM];

    function automatic logic [31:0] sat(input int a, input int b);
        longint s;
        s = longint'(a) + longint'(b);
        if (s > 64'sd2147483647)  return 32'h7FFF_FFFF;
        if (s < -64'sd2147483648) return 32'h8000_0000;
        return s[31:0];
    endfunction

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_status(input string tag);
        chk({tag, ".ready"},  32'(bif.ready),   32'(m_loading));
        chk({tag, ".loaded"}, 32'(bias_loaded), 32'(m_loaded));
        chk({tag, ".err"},    32'(load_err),    32'(m_err));
    endtask

    task automatic model_reset();
        foreach (m_bias[i]) m_bias[i] = 0;
        m_loading = 0; m_loaded = 0; m_err = 0; m_idx = 0; m_out = '0;
    endtask

    task automatic do_start();
        bif.load_start = 1'b1;
        tick();
        bif.load_start = 1'b0;
        m_loading = 1; m_loaded = 0; m_err = 0; m_idx = 0;
        chk_status("start");
    endtask

    task automatic beat(input int lo, input int hi, input bit last);
        bit was;
        bif.bias_data  = {hi, lo};
        bif.bias_valid = 1'b1;
        bif.bias_last  = last;
        was = m_loading;
        tick();
        bif.bias_valid = 1'b0;
        bif.bias_last  = 1'b0;
        if (was) begin
            m_bias[2*m_idx]   = lo;
            m_bias[2*m_idx+1] = hi;
            if (last && m_idx == BEAT_NUM-1) begin
                m_loaded = 1; m_loading = 0;
            end else if (last || m_idx == BEAT_NUM-1) begin
                m_err = 1; m_loading = 0;
            end
            m_idx++;
        end
        chk_status("beat");
    endtask

    task automatic full_load(input int b [CH_NUM], input int maxgap);
        for (int k = 0; k < BEAT_NUM; k++) begin
            beat(b[2*k], b[2*k+1], k == BEAT_NUM-1);
            if (k != BEAT_NUM-1) begin
                repeat ($urandom_range(maxgap)) begin
                    tick();
                    chk_status("gap");
                end
            end
        end
    endtask

    task automatic apply(input int ch, input int acc);
        bit was;
        acc_ch    = CH_W'(ch);
        acc_data  = acc;
        acc_valid = 1'b1;
        was = m_loaded;
        tick();
        acc_valid = 1'b0;
        if (was) m_out = sat(acc, m_bias[ch]);
        chk("out_valid", 32'(out_valid), 32'(was));
        chk("out_data",  out_data,       m_out);
    endtask

    task automatic verify_all();
        for (int ch = 0; ch < CH_NUM; ch++) apply(ch, 0);
    endtask

    initial begin
        s_rst_n        = 1'b0;
        bif.load_start = 1'b0;
        bif.bias_data  = '0;
        bif.bias_valid = 1'b0;
        bif.bias_last  = 1'b0;
        acc_data       = '0;
        acc_valid      = 1'b0;
        acc_ch         = '0;
        model_reset();
        #12;
        chk_status("reset");
        chk("reset.out_valid", 32'(out_valid), 32'd0);
        chk("reset.out_data",  out_data,       32'd0);
        @(negedge sclk);
        s_rst_n = 1'b1;

        // Normal back-to-back load, then the worked examples.
        apply(3, 77);
        do_start();
        full_load(B1, 0);
        apply(2, 1000);
        chk("t1.ch2", out_data, 32'hFFFF_FF9D);
        apply(15, 0);
        chk("t1.ch15", out_data, 32'hFFFF_FF52);

        // Saturation at both rails.
        apply(1, 32'h7FFF_FFF0);
        chk("t2.pos_sat", out_data, 32'h7FFF_FFFF);
        apply(12, 32'h8000_0010);
        chk("t2.neg_sat", out_data, 32'h8000_0000);
        verify_all();

        // Gapped reload of the same contents.
        do_start();
        full_load(B1, 3);
        verify_all();

        // Short frame: last on beat 4.
        do_start();
        for (int k = 0; k < 5; k++) beat(k, -k, k == 4);
        chk("t4.err_short", 32'(load_err), 32'd1);
        apply(0, 10);
        beat(1, 2, 1'b0);

        // Long frame: 8 beats without last.
        do_start();
        for (int k = 0; k < BEAT_NUM; k++) beat(k * 3, k * 7, 1'b0);
        chk("t4.err_long", 32'(load_err), 32'd1);
        apply(5, 10);

        // Overlap of load_start with an apply in DONE uses the old bias.
        do_start();
        full_load(B1, 0);
        acc_ch = '0; acc_data = '0; acc_valid = 1'b1; bif.load_start = 1'b1;
        tick();
        acc_valid = 1'b0; bif.load_start = 1'b0;
        m_out = sat(0, m_bias[0]);
        m_loading = 1; m_loaded = 0; m_err = 0; m_idx = 0;
        chk("t5.ovl_valid", 32'(out_valid), 32'd1);
        chk("t5.ovl_data",  out_data,       32'd129);
        chk_status("t5.ovl");
        full_load(B5, 1);
        apply(0, 0);
        chk("t5.reload5", out_data, 32'd5);

        // Restart mid-load, with a beat coinciding with load_start discarded.
        do_start();
        for (int k = 0; k < 4; k++) beat(int'($urandom), int'($urandom), 1'b0);
        bif.bias_data = {32'd999, 32'd999}; bif.bias_valid = 1'b1; bif.load_start = 1'b1;
        tick();
        bif.bias_valid = 1'b0; bif.load_start = 1'b0;
        m_loading = 1; m_loaded = 0; m_err = 0; m_idx = 0;
        chk_status("t5.restart");
        full_load(B1, 0);
        verify_all();

        // Reset mid-load.
        do_start();
        for (int k = 0; k < 4; k++) beat(k + 100, k + 200, 1'b0);
        #2;
        s_rst_n = 1'b0;
        #1;
        model_reset();
        chk_status("t6.rst");
        chk("t6.out_valid", 32'(out_valid), 32'd0);
        chk("t6.out_data",  out_data,       32'd0);
        @(negedge sclk);
        s_rst_n = 1'b1;
        do_start();
        full_load(B1, 0);
        verify_all();

        // Randomized loads and applies, biased toward the saturation rails.
        for (int r = 0; r < 4; r++) begin
            foreach (BR[i]) BR[i] = int'($urandom);
            do_start();
            full_load(BR, 2);
            for (int n = 0; n < 24; n++) begin
                int a;
                case ($urandom_range(2))
                    0: a = int'($urandom);
                    1: a = int'(32'h7FFF_FF00 | $urandom_range(255));
                    default: a = int'(32'h8000_0000 | $urandom_range(255));
                endcase
                apply(int'($urandom_range(CH_NUM-1)), a);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/layer_bias_rx.md
Name: layer_bias_rx

Overview:
Downstream consumer of the layer-0 bias stream. It accepts 64-bit beats, each carrying two signed 32-bit biases (low word = even channel, high word = odd channel), over a valid/ready/last handshake and unpacks them into a per-channel bias register file. Once loaded, it adds the selected channel's bias to convolution accumulator results, with signed saturation, through a one-stage registered pipeline.

Parameters:
CH_NUM, 16, number of output channels / bias words
BEAT_NUM, CH_NUM/2 = 8, beats per bias load
DW, 32, bias and accumulator width (signed)

Ports:
sclk  in  1  clock
s_rst_n  in  1  reset
load_start  in  1  pulse; arms a new bias load
bias_data  in  64  {bias[2k+1], bias[2k]}
bias_valid  in  1  beat valid
bias_last  in  1  final beat marker
ready  out  1  beat accept
acc_data  in  DW  signed accumulator result
acc_valid  in  1  accumulator result valid
acc_ch  in  log2(CH_NUM)  channel of acc_data
out_data  out  DW  saturated acc_data + bias[acc_ch]
out_valid  out  1  out_data valid
bias_loaded  out  1  bias file complete and usable
load_err  out  1  sticky framing error

Behaviour:
- Reset s_rst_n, asynchronous, active-low; clock sclk. On reset: state IDLE, beat counter 0, all bias registers 0, ready/out_valid/bias_loaded/load_err = 0, out_data = 0.
- FSM states:
  - IDLE: ready = 0. load_start moves to LOAD.
  - LOAD: ready = 1, combinational from state.
  - DONE: ready = 0, bias_loaded = 1.
- LOAD, beat accepted (bias_valid && ready), counter cnt:
  - Write bias[2*cnt] <= bias_data[31:0] and bias[2*cnt+1] <= bias_data[63:32].
  - cnt increments on each accepted beat.
- Framing in LOAD:
  - bias_last accepted with cnt == BEAT_NUM-1: go to DONE; bias_loaded = 1 on the next cycle.
  - bias_last accepted with cnt < BEAT_NUM-1: load_err <= 1, go to IDLE, bias_loaded stays 0.
  - Beat BEAT_NUM-1 accepted without bias_last: load_err <= 1, go to IDLE.
  - The beat is written in both error cases.
- bias_valid with ready = 0 is ignored; no data is written.
- load_start in any state:
  - cnt <= 0, bias_loaded <= 0, load_err <= 0, go to LOAD.
  - In LOAD this restarts the count at beat 0.
  - A beat accepted in the same cycle as load_start is discarded.
- Apply path, one-cycle latency:
  - acc_valid && bias_loaded: next cycle out_valid = 1 and out_data = sat(acc_data + bias[acc_ch]).
  - Otherwise out_valid = 0 and out_data holds its value.
- acc_valid while bias_loaded = 0 is dropped; no output is produced.
- Arithmetic: sign-extend both operands to DW+1 bits and add.
  - Result > 2^(DW-1)-1 clamps to 0x7FFFFFFF.
  - Result < -2^(DW-1) clamps to 0x80000000.
- acc_valid coinciding with load_start in DONE is processed with the old bias; the register file is unchanged until the first new beat.
- acc_ch >= CH_NUM is not legal for CH_NUM = 16.
- Back-to-back acc_valid is sustained at 1 result per cycle; there is no backpressure on the apply path.
- Reset mid-load returns to the reset state; partial bias contents are cleared.

Decomposition:
- Package layer_bias_pkg: CH_NUM, BEAT_NUM, DW, CH_W = $clog2(CH_NUM), FSM state enum {IDLE, LOAD, DONE}, saturation constants SAT_MAX / SAT_MIN.
- One sub-module, bias_sat_add: combinational DW-bit signed add with saturation, instantiated in the apply stage before the output register.
- FSM, counter and register file stay in the top module.

Test Plan:
1. Normal load: load_start, then 8 beats of biases {129, 395, -1099, 473, 119, 698, 537, 818, -108, 1009, 364, 225, -2467, -162, 368, -174}, continuous valid, last on beat 7 -> bias_loaded = 1 the cycle after beat 7. Then acc_data = 1000, acc_ch = 2 -> out_valid one cycle later, out_data = -99. acc_ch = 15, acc_data = 0 -> out_data = -174.
2. Saturation: after load, acc_data = 0x7FFFFFF0 on ch1 (+395) -> 0x7FFFFFFF; acc_data = 0x80000010 on ch12 (-2467) -> 0x80000000.
3. Gapped valid: idle cycles between beats, last on beat 7 -> identical contents to scenario 1; ready stays 1 throughout LOAD.
4. Framing errors:
   - last on beat 4 -> load_err = 1, bias_loaded = 0, FSM in IDLE; a following acc_valid gives no out_valid.
   - 8 beats with no last -> load_err = 1.
5. Reload and overlap: in DONE, acc_valid ch0 (acc 0) in the same cycle as load_start -> out_data = 129. Reload with all biases = 5 -> ch0 result for acc 0 is 5. load_start after beat 3 restarts the count at beat 0.
6. Reset mid-load: assert s_rst_n = 0 after beat 3 -> all outputs 0, bias file 0. A new full load then works as in scenario 1.
